// File: rtl/wb_master_bif_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_bif_pkg
// Shared definitions for the Wishbone classic bus initiator:
//   - FSM state encoding (IDLE / BUS)
//   - Wishbone address / data / select widths
//   - helper that forms the response data word
// No ports (package).
// -----------------------------------------------------------------------------
package wb_master_bif_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_t;

   // Read data is passed through on a normal read completion; writes return 0.
   function automatic logic [WB_DAT_W-1:0] f_rsp_data(input logic          i_we,
                                                      input logic [WB_DAT_W-1:0] i_dat);
      logic [WB_DAT_W-1:0] w_res;
      if (i_we) begin
         w_res = {WB_DAT_W{1'b0}};
      end else begin
         w_res = i_dat;
      end
      return w_res;
   endfunction

endpackage

// File: rtl/wb_master_bif_if.sv
// -----------------------------------------------------------------------------
// wb_master_bif_if
// Groups the request/response handshake and the Wishbone master bus.
//   modport master : the bridge's view (drives req_ready, rsp_*, wbm_* outputs)
//   modport slave  : the environment's view (requester plus addressed slave)
// Signals:
//   req_valid_i/req_ready_o/req_we_i/req_adr_i/req_dat_i/req_sel_i - request
//   rsp_valid_o/rsp_dat_o/rsp_err_o                                - response
//   wbm_adr_o/wbm_dat_o/wbm_dat_i/wbm_sel_o/wbm_we_o/wbm_cyc_o/
//   wbm_stb_o/wbm_ack_i                                            - Wishbone
// -----------------------------------------------------------------------------
interface wb_master_bif_if;
   import wb_master_bif_pkg::*;

   // request port
   logic                req_valid_i;
   logic                req_ready_o;
   logic                req_we_i;
   logic [WB_ADR_W-1:0] req_adr_i;
   logic [WB_DAT_W-1:0] req_dat_i;
   logic [WB_SEL_W-1:0] req_sel_i;

   // response port
   logic                rsp_valid_o;
   logic [WB_DAT_W-1:0] rsp_dat_o;
   logic                rsp_err_o;

   // Wishbone master bus
   logic [WB_ADR_W-1:0] wbm_adr_o;
   logic [WB_DAT_W-1:0] wbm_dat_o;
   logic [WB_DAT_W-1:0] wbm_dat_i;
   logic [WB_SEL_W-1:0] wbm_sel_o;
   logic                wbm_we_o;
   logic                wbm_cyc_o;
   logic                wbm_stb_o;
   logic                wbm_ack_i;

   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
      output req_ready_o,
      output rsp_valid_o, rsp_dat_o, rsp_err_o,
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
      input  req_ready_o,
      input  rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      output wbm_dat_i, wbm_ack_i
   );

endinterface

// File: rtl/wb_master_bif_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_master_bif_timeout_cnt
// Wait-cycle counter for an outstanding Wishbone strobe.
// Ports:
//   i_clk    - bus clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_clr    - synchronous clear (new transfer accepted)
//   i_en     - count one more wait cycle
//   o_expire - counter has reached TIMEOUT-1; always 0 when TIMEOUT == 0
// -----------------------------------------------------------------------------
module wb_master_bif_timeout_cnt #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   // Terminal count; the value is irrelevant when the timeout is disabled.
   localparam logic [TO_W-1:0] C_TERM = (TIMEOUT == 0) ? {TO_W{1'b0}} : TO_W'(TIMEOUT - 1);
   localparam logic            C_ENA  = (TIMEOUT != 0) ? 1'b1 : 1'b0;

   logic [TO_W-1:0] r_cnt;

   // Wait-cycle counter: clear wins over increment.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= {TO_W{1'b0}};
      end else if (i_clr) begin
         r_cnt <= {TO_W{1'b0}};
      end else if (i_en) begin
         r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_expire = C_ENA & (r_cnt == C_TERM);

endmodule

// File: rtl/wb_master_bif.sv
// -----------------------------------------------------------------------------
// wb_master_bif
// Wishbone classic single-beat initiator. Accepts one valid/ready request at a
// time, holds cyc/stb until the slave acks, returns read data, and aborts with
// an error response if no ack arrives within TIMEOUT strobe cycles.
// Ports:
//   clk_i - bus clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - request/response handshake and Wishbone master bus (master view)
// All bus outputs except req_ready_o are registered; wbm_ack_i/wbm_dat_i only
// reach outputs through flops.
// -----------------------------------------------------------------------------
module wb_master_bif
   import wb_master_bif_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   wb_master_bif_if.master   bus
);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [WB_ADR_W-1:0] r_adr,      w_adr_nxt;
   logic [WB_DAT_W-1:0] r_dat,      w_dat_nxt;
   logic [WB_SEL_W-1:0] r_sel,      w_sel_nxt;
   logic                r_we,       w_we_nxt;
   logic                r_cyc,      w_cyc_nxt;
   logic                r_stb,      w_stb_nxt;
   logic                r_rsp_valid, w_rsp_valid_nxt;
   logic [WB_DAT_W-1:0] r_rsp_dat,  w_rsp_dat_nxt;
   logic                r_rsp_err,  w_rsp_err_nxt;

   logic                w_cnt_clr;
   logic                w_cnt_en;
   logic                w_expire;

   wb_master_bif_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout_cnt (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .o_expire (w_expire)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output logic. Address/data/sel/we hold in IDLE;
   // rsp_dat/rsp_err hold between responses; rsp_valid is a one-cycle pulse.
   always_comb begin
      w_state_nxt     = r_state;
      w_adr_nxt       = r_adr;
      w_dat_nxt       = r_dat;
      w_sel_nxt       = r_sel;
      w_we_nxt        = r_we;
      w_cyc_nxt       = r_cyc;
      w_stb_nxt       = r_stb;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_dat_nxt   = r_rsp_dat;
      w_rsp_err_nxt   = r_rsp_err;
      w_cnt_clr       = 1'b0;
      w_cnt_en        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // req_ready_o is high in IDLE, so valid alone completes the handshake.
            // A stray wbm_ack_i here is deliberately ignored.
            if (bus.req_valid_i) begin
               w_adr_nxt   = bus.req_adr_i;
               w_dat_nxt   = bus.req_dat_i;
               w_sel_nxt   = bus.req_sel_i;
               w_we_nxt    = bus.req_we_i;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_BUS;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUS: begin
            // Ack is checked first so a last-cycle ack still completes normally.
            if (bus.wbm_ack_i) begin
               w_cyc_nxt       = 1'b0;
               w_stb_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b0;
               w_rsp_dat_nxt   = f_rsp_data(r_we, bus.wbm_dat_i);
               w_state_nxt     = ST_IDLE;
            end else if (w_expire) begin
               w_cyc_nxt       = 1'b0;
               w_stb_nxt       = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_dat_nxt   = {WB_DAT_W{1'b0}};
               w_state_nxt     = ST_IDLE;
            end else begin
               w_cnt_en        = 1'b1;
               w_state_nxt     = ST_BUS;
            end
         end
         default: begin
            w_cyc_nxt   = 1'b0;
            w_stb_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered bus and response outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_adr       <= {WB_ADR_W{1'b0}};
         r_dat       <= {WB_DAT_W{1'b0}};
         r_sel       <= {WB_SEL_W{1'b0}};
         r_we        <= 1'b0;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_dat   <= {WB_DAT_W{1'b0}};
         r_rsp_err   <= 1'b0;
      end else begin
         r_adr       <= w_adr_nxt;
         r_dat       <= w_dat_nxt;
         r_sel       <= w_sel_nxt;
         r_we        <= w_we_nxt;
         r_cyc       <= w_cyc_nxt;
         r_stb       <= w_stb_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_dat   <= w_rsp_dat_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign bus.req_ready_o = (r_state == ST_IDLE);
   assign bus.rsp_valid_o = r_rsp_valid;
   assign bus.rsp_dat_o   = r_rsp_dat;
   assign bus.rsp_err_o   = r_rsp_err;
   assign bus.wbm_adr_o   = r_adr;
   assign bus.wbm_dat_o   = r_dat;
   assign bus.wbm_sel_o   = r_sel;
   assign bus.wbm_we_o    = r_we;
   assign bus.wbm_cyc_o   = r_cyc;
   assign bus.wbm_stb_o   = r_stb;

endmodule

// File: tb/tb_wb_master_bif.sv
// -----------------------------------------------------------------------------
// tb_wb_master_bif
// Directed bench for wb_master_bif with TIMEOUT = 4. Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_wb_master_bif;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   n_cyc_hi;
   int   n_rsp;
   int   n_cyc_total;

   wb_master_bif_if bus ();

   wb_master_bif #(
      .TIMEOUT (4),
      .TO_W    (8)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [1:0] sel);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_adr_i   = adr;
      bus.req_dat_i   = dat;
      bus.req_sel_i   = sel;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_adr_i   = 32'h0;
      bus.req_dat_i   = 32'h0;
      bus.req_sel_i   = 2'b00;
      bus.wbm_dat_i   = 32'h0;
      bus.wbm_ack_i   = 1'b0;

      // ---- reset state ----
      #2;
      chk1 ("rst_ready",     bus.req_ready_o, 1'b1);
      chk1 ("rst_cyc",       bus.wbm_cyc_o,   1'b0);
      chk1 ("rst_stb",       bus.wbm_stb_o,   1'b0);
      chk1 ("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk32("rst_adr",       bus.wbm_adr_o,   32'h0);
      chk32("rst_rsp_dat",   bus.rsp_dat_o,   32'h0);
      // request offered during reset must not be accepted
      issue(1'b0, 32'h0000_00AA, 32'h0, 2'b11);
      tick();
      tick();
      chk1 ("rst_noaccept_cyc", bus.wbm_cyc_o,   1'b0);
      chk1 ("rst_ready_hold",   bus.req_ready_o, 1'b1);
      rst = 1'b0;
      bus.req_valid_i = 1'b0;
      tick();
      chk1 ("post_rst_cyc", bus.wbm_cyc_o, 1'b0);

      // ---- read, zero-wait slave ----
      issue(1'b0, 32'h0000_0010, 32'h0, 2'b11);
      tick();
      bus.req_valid_i = 1'b0;
      chk1 ("rd0_cyc",   bus.wbm_cyc_o,   1'b1);
      chk1 ("rd0_stb",   bus.wbm_stb_o,   1'b1);
      chk1 ("rd0_we",    bus.wbm_we_o,    1'b0);
      chk32("rd0_adr",   bus.wbm_adr_o,   32'h0000_0010);
      chk1 ("rd0_ready", bus.req_ready_o, 1'b0);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'hDEAD_BEEF;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk1 ("rd0_cyc_lo", bus.wbm_cyc_o,   1'b0);
      chk1 ("rd0_rvalid", bus.rsp_valid_o, 1'b1);
      chk32("rd0_rdat",   bus.rsp_dat_o,   32'hDEAD_BEEF);
      chk1 ("rd0_rerr",   bus.rsp_err_o,   1'b0);
      chk1 ("rd0_ready1", bus.req_ready_o, 1'b1);
      tick();
      chk1 ("rd0_rvalid_clr", bus.rsp_valid_o, 1'b0);
      chk32("rd0_rdat_hold",  bus.rsp_dat_o,   32'hDEAD_BEEF);

      // ---- write, 3 wait states ----
      issue(1'b1, 32'h0000_1000, 32'h1234_5678, 2'b11);
      bus.wbm_dat_i = 32'hFFFF_FFFF;
      tick();
      bus.req_valid_i = 1'b0;
      bus.req_dat_i   = 32'h0;
      for (int i = 0; i < 4; i++) begin
         chk1 ("wr_cyc",    bus.wbm_cyc_o,   1'b1);
         chk1 ("wr_we",     bus.wbm_we_o,    1'b1);
         chk32("wr_adr",    bus.wbm_adr_o,   32'h0000_1000);
         chk32("wr_dat",    bus.wbm_dat_o,   32'h1234_5678);
         chk32("wr_sel",    {30'h0, bus.wbm_sel_o}, 32'h3);
         chk1 ("wr_rvalid", bus.rsp_valid_o, 1'b0);
         if (i == 3) begin
            bus.wbm_ack_i = 1'b1;
         end
         tick();
      end
      bus.wbm_ack_i = 1'b0;
      chk1 ("wr_cyc_lo", bus.wbm_cyc_o,   1'b0);
      chk1 ("wr_rvalid", bus.rsp_valid_o, 1'b1);
      chk32("wr_rdat",   bus.rsp_dat_o,   32'h0);
      chk1 ("wr_rerr",   bus.rsp_err_o,   1'b0);
      tick();
      chk1 ("wr_single", bus.rsp_valid_o, 1'b0);

      // ---- back-to-back, valid held high, zero-wait slave ----
      n_cyc_hi    = 0;
      n_rsp       = 0;
      n_cyc_total = 0;
      issue(1'b0, 32'h0000_0020, 32'h0, 2'b01);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk1 ("b2b_cyc_hi", bus.wbm_cyc_o, 1'b1);
         chk32("b2b_adr",    bus.wbm_adr_o, 32'h0000_0020 + 32'(k * 4));
         if (bus.wbm_cyc_o) n_cyc_hi++;
         n_cyc_total++;
         bus.wbm_ack_i = 1'b1;
         bus.wbm_dat_i = 32'h1111_0000 + 32'(k);
         tick();
         bus.wbm_ack_i = 1'b0;
         chk1 ("b2b_cyc_lo", bus.wbm_cyc_o,   1'b0);
         chk1 ("b2b_ready",  bus.req_ready_o, 1'b1);
         chk32("b2b_rdat",   bus.rsp_dat_o,   32'h1111_0000 + 32'(k));
         if (bus.rsp_valid_o) n_rsp++;
         n_cyc_total++;
         if (k < 3) begin
            bus.req_adr_i = 32'h0000_0020 + 32'((k + 1) * 4);
         end else begin
            bus.req_valid_i = 1'b0;
         end
         tick();
      end
      chk_int("b2b_cyc_count", n_cyc_hi,    4);
      chk_int("b2b_rsp_count", n_rsp,       4);
      chk_int("b2b_cycles",    n_cyc_total, 8);
      chk1   ("b2b_idle_after", bus.wbm_cyc_o, 1'b0);

      // ---- timeout, no ack ----
      issue(1'b0, 32'hF000_0000, 32'h0, 2'b11);
      tick();
      bus.req_valid_i = 1'b0;
      n_cyc_hi = 0;
      for (int i = 0; i < 4; i++) begin
         chk1("to_stb",    bus.wbm_stb_o,   1'b1);
         chk1("to_rvalid", bus.rsp_valid_o, 1'b0);
         if (bus.wbm_stb_o) n_cyc_hi++;
         tick();
      end
      chk_int("to_stb_cycles", n_cyc_hi, 4);
      chk1 ("to_stb_lo", bus.wbm_stb_o,   1'b0);
      chk1 ("to_cyc_lo", bus.wbm_cyc_o,   1'b0);
      chk1 ("to_rvalid", bus.rsp_valid_o, 1'b1);
      chk1 ("to_rerr",   bus.rsp_err_o,   1'b1);
      chk32("to_rdat",   bus.rsp_dat_o,   32'h0);
      tick();
      chk1 ("to_rvalid_clr", bus.rsp_valid_o, 1'b0);
      chk1 ("to_rerr_hold",  bus.rsp_err_o,   1'b1);

      // ---- ack on the last timeout cycle wins ----
      issue(1'b0, 32'hF000_0004, 32'h0, 2'b11);
      tick();
      bus.req_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("ackto_stb", bus.wbm_stb_o, 1'b1);
         if (i == 3) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = 32'hCAFE_0004;
         end
         tick();
      end
      bus.wbm_ack_i = 1'b0;
      chk1 ("ackto_rvalid", bus.rsp_valid_o, 1'b1);
      chk1 ("ackto_rerr",   bus.rsp_err_o,   1'b0);
      chk32("ackto_rdat",   bus.rsp_dat_o,   32'hCAFE_0004);
      tick();

      // ---- stale ack in IDLE ----
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h0000_0055;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk1 ("stale_rvalid", bus.rsp_valid_o, 1'b0);
      chk1 ("stale_cyc",    bus.wbm_cyc_o,   1'b0);
      chk1 ("stale_ready",  bus.req_ready_o, 1'b1);
      chk32("stale_rdat",   bus.rsp_dat_o,   32'hCAFE_0004);
      tick();
      chk1 ("stale_rvalid2", bus.rsp_valid_o, 1'b0);
      issue(1'b0, 32'h0000_0030, 32'h0, 2'b10);
      tick();
      bus.req_valid_i = 1'b0;
      chk1 ("stale_rd_cyc", bus.wbm_cyc_o, 1'b1);
      tick();
      chk1 ("stale_rd_wait", bus.wbm_cyc_o, 1'b1);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h0BAD_F00D;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk1 ("stale_rd_rvalid", bus.rsp_valid_o, 1'b1);
      chk32("stale_rd_rdat",   bus.rsp_dat_o,   32'h0BAD_F00D);
      tick();

      // ---- reset in the middle of a wait state ----
      issue(1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 2'b11);
      tick();
      bus.req_valid_i = 1'b0;
      chk1 ("mrst_cyc_pre", bus.wbm_cyc_o, 1'b1);
      tick();
      chk1 ("mrst_cyc_wait", bus.wbm_cyc_o, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1 ("mrst_cyc_async", bus.wbm_cyc_o,   1'b0);
      chk1 ("mrst_stb_async", bus.wbm_stb_o,   1'b0);
      chk1 ("mrst_ready",     bus.req_ready_o, 1'b1);
      chk32("mrst_adr",       bus.wbm_adr_o,   32'h0);
      chk32("mrst_rdat",      bus.rsp_dat_o,   32'h0);
      tick();
      chk1 ("mrst_rvalid", bus.rsp_valid_o, 1'b0);
      rst = 1'b0;
      tick();
      chk1 ("mrst_rvalid2", bus.rsp_valid_o, 1'b0);
      chk1 ("mrst_cyc_idle", bus.wbm_cyc_o,  1'b0);
      issue(1'b0, 32'h0000_0050, 32'h0, 2'b11);
      tick();
      bus.req_valid_i = 1'b0;
      chk1 ("mrst_rd_cyc", bus.wbm_cyc_o, 1'b1);
      chk32("mrst_rd_adr", bus.wbm_adr_o, 32'h0000_0050);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = 32'h600D_CAFE;
      tick();
      bus.wbm_ack_i = 1'b0;
      chk1 ("mrst_rd_rvalid", bus.rsp_valid_o, 1'b1);
      chk1 ("mrst_rd_rerr",   bus.rsp_err_o,   1'b0);
      chk32("mrst_rd_rdat",   bus.rsp_dat_o,   32'h600D_CAFE);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
